// File: rtl/sched_pkg.sv
// sched_pkg: shared types, constants and round-robin pick helper for shared_resource_scheduler.
package sched_pkg;

    typedef enum logic {IDLE, OWNED} sched_state_t;

    localparam int SCHED_CNT_W   = 16;
    localparam int SCHED_MAX_REQ = 8;
    localparam int SCHED_IDX_W   = 3;

    typedef struct packed {
        logic                   found;
        logic [SCHED_IDX_W-1:0] idx;
    } pick_t;

    // Scans downwards so the lowest rotated offset from ptr is the last hit kept.
    function automatic pick_t rr_pick(input logic [SCHED_MAX_REQ-1:0] vec,
                                      input logic [SCHED_IDX_W-1:0] ptr,
                                      input logic [SCHED_MAX_REQ-1:0] exclude,
                                      input int n);
        pick_t r;
        logic [SCHED_IDX_W-1:0] j;
        r = '0;
        for (int i = SCHED_MAX_REQ - 1; i >= 0; i--) begin
            j = SCHED_IDX_W'((int'(ptr) + i) % n);
            if (i < n && vec[j] && !exclude[j]) begin
                r.found = 1'b1;
                r.idx   = j;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational rotate-priority encoder, first set bit of vec at or after ptr, skipping exclude.
module rr_picker
    import sched_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] vec,
    input  logic [NUM_REQ-1:0] exclude,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   idx,
    output logic               found
);

    pick_t p;

    always_comb begin
        p     = rr_pick(SCHED_MAX_REQ'(vec), SCHED_IDX_W'(ptr), SCHED_MAX_REQ'(exclude), NUM_REQ);
        idx   = IDX_W'(p.idx);
        found = p.found;
    end

endmodule

// File: rtl/shared_resource_scheduler.sv
// shared_resource_scheduler: round-robin owner scheduler with hold-limit preemption and per-requester stall.
// Define SHARED_RESOURCE_SCHED_STATS_EN to add saturating grant_cnt/preempt_cnt outputs.
module shared_resource_scheduler
    import sched_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int MAX_HOLD = 8,
    parameter int IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ-1:0]              done,
    input  logic [NUM_REQ-1:0]              flush,
    output logic [NUM_REQ-1:0]              grant,
    output logic [IDX_W-1:0]                grant_idx,
    output logic                            grant_valid,
    output logic [NUM_REQ-1:0]              stall,
    output logic                            preempt
`ifdef SHARED_RESOURCE_SCHED_STATS_EN
    ,
    output logic [NUM_REQ*SCHED_CNT_W-1:0]  grant_cnt,
    output logic [SCHED_CNT_W-1:0]          preempt_cnt
`endif
);

    sched_state_t       state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [7:0]         hold_cnt;
    logic [NUM_REQ-1:0] ereq;
    logic [NUM_REQ-1:0] others;
    logic [IDX_W-1:0]   nxt_ptr;
    logic [IDX_W-1:0]   pick_ptr;
    logic [IDX_W-1:0]   win;
    logic               found;
    logic               rel;
    logic               hit;
    logic               start;

    always_comb begin
        ereq     = req & ~flush;
        others   = ereq & ~grant;
        nxt_ptr  = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        rel      = (state == OWNED) && (!req[grant_idx] || done[grant_idx] || flush[grant_idx]);
        hit      = (state == OWNED) && !rel && (|others) && (hold_cnt == 8'(MAX_HOLD));
        pick_ptr = (state == OWNED) ? nxt_ptr : rr_ptr;
        start    = found && ((state == IDLE) || rel || hit);
    end

    assign stall       = others;
    assign grant_valid = |grant;

    // Excluding the current grant keeps a released/preempted owner out of its own handoff.
    rr_picker #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
        .vec     (ereq),
        .exclude (grant),
        .ptr     (pick_ptr),
        .idx     (win),
        .found   (found)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            grant     <= '0;
            grant_idx <= '0;
            rr_ptr    <= '0;
            hold_cnt  <= '0;
            preempt   <= 1'b0;
        end else if (state == IDLE || rel || hit) begin
            preempt  <= hit;
            hold_cnt <= '0;
            if (state == OWNED)
                rr_ptr <= nxt_ptr;
            state     <= found ? OWNED : IDLE;
            grant     <= found ? NUM_REQ'(1) << win : '0;
            grant_idx <= found ? win : '0;
        end else begin
            preempt  <= 1'b0;
            hold_cnt <= (|others) ? hold_cnt + 8'd1 : '0;
        end
    end

`ifdef SHARED_RESOURCE_SCHED_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant_cnt   <= '0;
            preempt_cnt <= '0;
        end else begin
            if (start && grant_cnt[int'(win)*SCHED_CNT_W +: SCHED_CNT_W] != '1)
                grant_cnt[int'(win)*SCHED_CNT_W +: SCHED_CNT_W] <= grant_cnt[int'(win)*SCHED_CNT_W +: SCHED_CNT_W] + 1'b1;
            if (hit && preempt_cnt != '1)
                preempt_cnt <= preempt_cnt + 1'b1;
        end
    end
`endif

endmodule
